instr_prefetch_buf: RTL
=======================

// Module: instr_prefetch_buf
// PURPOSE
//  Initiator for the instruction-RAM port (en/addr/we/be/wdata/rdata, fixed 1-cycle read latency, no stall).
//  Issues sequential word reads, buffers returned words with their addresses in a small FIFO and presents
//  them to the core fetch stage over valid/ready. Sits between core IF stage and instr RAM/boot ROM wrapper.
//  Branch redirect flushes buffered and in-flight words.
// PARAMETERS
//  ADDR_WIDTH  16        byte-address width of RAM port; addresses word-aligned, [1:0] always 2'b00
//  DEPTH       4         FIFO entries; power of two, >= 2
//  BOOT_ADDR   'h0000    fetch address after reset
// PORTS
//  clk            in   1           clock; all logic on posedge
//  rst            in   1           reset; one clock, synchronous, active-high
//  fetch_en_i     in   1           level; 1 = issue reads, 0 = stop issuing (in-flight still completes)
//  branch_i       in   1           1-cycle redirect pulse
//  branch_addr_i  in   ADDR_WIDTH  redirect target; [1:0] ignored (treated as 0)
//  instr_valid_o  out  1           FIFO head valid
//  instr_ready_i  in   1           consumer accepts head
//  instr_rdata_o  out  32          head instruction word
//  instr_addr_o   out  ADDR_WIDTH  byte address of head word
//  mem_en_o       out  1           read request this cycle
//  mem_addr_o     out  ADDR_WIDTH  request address
//  mem_we_o       out  1           constant 0
//  mem_be_o       out  4           constant 4'hF
//  mem_wdata_o    out  32          constant 0
//  mem_rdata_i    in   32          read data, valid exactly 1 cycle after mem_en_o
//  busy_o         out  1           request in flight or FIFO non-empty
// BEHAVIOUR
//  Reset: FIFO empty, instr_valid_o=0, mem_en_o=0, in-flight flag=0, kill flag=0, next_addr=BOOT_ADDR.
//  Reset mid-operation discards all state; response arriving the cycle after reset is ignored.
//  States: IDLE (fetch_en_i=0) / RUN (fetch_en_i=1); only IDLE->RUN / RUN->IDLE on fetch_en_i level.
//  Issue: mem_en_o=1 iff RUN & !branch_i & (occupancy + inflight) < DEPTH; mem_addr_o=next_addr;
//   next_addr += 4 per issue, modulo 2^ADDR_WIDTH (wraps to 0, no error).
//  Return: cycle after issue, mem_rdata_i and issued address pushed unless kill flag set.
//  Latency: issue in N -> push end of N+1 -> instr_valid_o in N+2 (no bypass). Steady state 1 word/cycle
//   with instr_ready_i=1 and DEPTH>=2.
//  Pop: instr_valid_o & instr_ready_i. Push+pop same cycle: occupancy unchanged; full+push impossible by credits.
//  instr_rdata_o/instr_addr_o stable while instr_valid_o=1 and !instr_ready_i (no flush).
//  Branch (cycle B): handshake in B valid (consumer took it); then FIFO cleared end of B; request issued in B-1
//   marked killed (no push in B); no issue in B; next_addr=branch_addr_i & ~3; first target issue B+1
//   if RUN; instr_valid_o=0 in B+1.
//  Branch while IDLE: same flush; next_addr updated; no issue until fetch_en_i=1.
//  Back-to-back branches: last one wins.
//  busy_o = inflight | (occupancy != 0).
// STRUCTURE
//  Package instr_prefetch_pkg: INSTR_WIDTH=32, MEM_BE_ALL=4'hF, state enum {IDLE,RUN}, entry struct {addr,rdata}.
//  Sub-module prefetch_fifo (DEPTH, entry type; push/pop/flush, count_o, head_o; flush beats push).
//  Top: state, next_addr, inflight/kill flags, credit check, port ties.
// TESTING
//  Reset, fetch_en=1, RAM[0..3]=A0..A3, ready=1 -> mem_addr 0,4,8,C on consecutive cycles;
//   valid first 2 cycles after first issue, words A0..A3 at addr 0..C in order.
//  ready=0 for 10 cycles, DEPTH=4 -> exactly 4 issues then mem_en_o=0; head stable; ready=1 -> drains,
//   issue resumes next cycle.
//  Branch to 'h0102 while 3 buffered + 1 in flight -> no push from killed read, valid=0 next cycle,
//   next mem_addr='h0100, first delivered addr 'h0100.
//  next_addr='hFFF8, run -> addresses FFF8, FFFC, 0000, 0004.
//  fetch_en 1->0 with request in flight -> that word delivered, no further issue, busy_o falls after drain.
//  rst asserted one cycle mid-stream -> cycle after: valid=0, mem_en_o=0; next issue at BOOT_ADDR;
//   stale rdata never delivered.

Source files
------------

// File: rtl/instr_prefetch_buf_pkg.sv
// Shared types for the instruction prefetch buffer.
// Entry layout, memory port constants and FSM states.
package instr_prefetch_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int IPB_ADDR_WIDTH = 16;
  localparam logic [3:0] MEM_BE_ALL = 4'hF;

  typedef logic [INSTR_WIDTH-1:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Entry address width is fixed here; the top's ADDR_WIDTH must match.
  typedef struct packed {
    logic [IPB_ADDR_WIDTH-1:0] addr;
    word_t                     rdata;
  } entry_t;

  function automatic logic [IPB_ADDR_WIDTH-1:0] word_align(
    input logic [IPB_ADDR_WIDTH-1:0] a
  );
    return {a[IPB_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_prefetch_buf_fifo.sv
// Small synchronous FIFO holding fetched words with their addresses.
// Flush beats push; push when full and pop when empty are ignored.
module prefetch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [31:0],
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  entry_t        data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output entry_t        head_o,
  output logic [CW-1:0] count_o
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i & ~flush_i
                 & (count_q != CW'(DEPTH));
  assign do_pop  = pop_i & ~flush_i
                 & (count_q != '0);

  always_ff @(posedge clk) begin
    if (do_push & ~rst) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst | flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem[rd_ptr];
  assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch_buf.sv
// Sequential instruction prefetcher with credit-limited issue.
// Buffers RAM words for the fetch stage; redirects flush everything.
module instr_prefetch_buf
  import instr_prefetch_pkg::*;
#(
  parameter int ADDR_WIDTH = IPB_ADDR_WIDTH,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           instr_rdata_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  busy_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int UW = CW + 1;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] next_addr_q;
  logic [ADDR_WIDTH-1:0] issue_addr_q;
  logic [ADDR_WIDTH-1:0] target;
  logic                  inflight_q;
  logic                  kill;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic [CW-1:0]         count;
  logic [UW-1:0]         used;
  entry_t                head;
  entry_t                push_entry;

  assign target = {branch_addr_i[ADDR_WIDTH-1:2], 2'b00};

  // Buffered plus in-flight words bound issue, so push never hits full.
  assign used  = UW'(count) + UW'(inflight_q);
  assign issue = (state_q == RUN) & ~branch_i
               & (used < UW'(DEPTH));

  // A redirect kills the word returning this cycle.
  assign kill = branch_i;
  assign push = inflight_q & ~kill;
  assign pop  = instr_valid_o & instr_ready_i;

  always_comb begin
    push_entry       = '0;
    push_entry.addr  = IPB_ADDR_WIDTH'(issue_addr_q);
    push_entry.rdata = mem_rdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      next_addr_q  <= BOOT_ADDR;
      issue_addr_q <= BOOT_ADDR;
      inflight_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE:    if (fetch_en_i) state_q <= RUN;
        RUN:     if (!fetch_en_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      unique case (1'b1)
        branch_i: next_addr_q <= target;
        issue:    next_addr_q <= next_addr_q
                               + ADDR_WIDTH'(4);
        default:  next_addr_q <= next_addr_q;
      endcase
      if (issue) begin
        issue_addr_q <= next_addr_q;
      end
      inflight_q <= issue;
    end
  end

  prefetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .flush_i (branch_i),
    .head_o  (head),
    .count_o (count)
  );

  assign instr_valid_o = (count != '0);
  assign instr_rdata_o = head.rdata;
  assign instr_addr_o  = ADDR_WIDTH'(head.addr);

  assign mem_en_o    = issue;
  assign mem_addr_o  = next_addr_q;
  assign mem_we_o    = 1'b0;
  assign mem_be_o    = MEM_BE_ALL;
  assign mem_wdata_o = '0;

  assign busy_o = inflight_q | (count != '0);

endmodule
